// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: shared state encoding, reset address and instruction field positions
package instr_fetch_pkg;
   typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_t;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam int TGT_MSB = 25;
   localparam int IMM_MSB = 15;
   // pc+4 plus the word offset; the 16-bit immediate is sign-extended from bit 15
   function automatic logic [31:0] br_target(input logic [31:0] pc4, input logic [IMM_MSB:0] imm);
      return pc4 + {{14{imm[IMM_MSB]}}, imm, 2'b00};
   endfunction
endpackage

// File: rtl/instr_fetch_next_pc_sel.sv
// next_pc_sel: combinational redirect target and branch-taken evaluation
//   in : pc_plus4, tgt (instr[25:0]), rs_val, beq/bne/bgez/bltz/bgtz/blez/jump0/jump1,
//        jr_sel, rt0, zero, neg
//   out: next_pc (address to fetch after consume), misaligned (jr target low bits set)
module next_pc_sel
   import instr_fetch_pkg::*;
(
   input  logic [31:0]      pc_plus4,
   input  logic [TGT_MSB:0] tgt,
   input  logic [31:0]      rs_val,
   input  logic             beq,
   input  logic             bne,
   input  logic             bgez,
   input  logic             bltz,
   input  logic             bgtz,
   input  logic             blez,
   input  logic             jump0,
   input  logic             jump1,
   input  logic             jr_sel,
   input  logic             rt0,
   input  logic             zero,
   input  logic             neg,
   output logic [31:0]      next_pc,
   output logic             misaligned
);
   logic taken;
   logic jr;
   // bgez and bltz share an opcode, so both flags arrive together and rt0 picks one
   assign taken = (beq & zero) | (bne & ~zero) | (bgtz & ~neg & ~zero) | (blez & (neg | zero))
                | (bgez & rt0 & ~neg) | (bltz & ~rt0 & neg);
   assign jr = jump1 & jr_sel;
   assign next_pc = jr ? {rs_val[31:2], 2'b00} :
                    (jump0 | jump1) ? {pc_plus4[31:28], tgt, 2'b00} :
                    taken ? br_target(pc_plus4, tgt[IMM_MSB:0]) : pc_plus4;
   assign misaligned = jr & |rs_val[1:0];
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: two-state fetch unit holding one instruction until decode consumes it
//   in : clk, rst_n, imem_rdy, imem_rdata, dec_ready, redirect controls, zero/neg, rs_val
//   out: imem_req, imem_addr, instr, instr_valid, pc, pc_plus4, addr_err
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rdy,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic        instr_valid,
   input  logic        dec_ready,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   input  logic        beq,
   input  logic        bne,
   input  logic        bgez,
   input  logic        bltz,
   input  logic        bgtz,
   input  logic        blez,
   input  logic        jump0,
   input  logic        jump1,
   input  logic        jr_sel,
   input  logic        rt0,
   input  logic        zero,
   input  logic        neg,
   input  logic [31:0] rs_val,
   output logic        addr_err
);
   state_t      state;
   logic [31:0] next_pc;
   logic        misaligned;
   logic        consume;
   // request and valid are pure state decodes so reset drops them without waiting for a clock
   assign imem_req    = state == FETCH;
   assign instr_valid = state == HOLD;
   assign imem_addr   = pc;
   assign pc_plus4    = pc + 32'd4;
   assign consume     = instr_valid & dec_ready;
   next_pc_sel u_sel (
      .pc_plus4  (pc_plus4),
      .tgt       (instr[TGT_MSB:0]),
      .rs_val    (rs_val),
      .beq       (beq),
      .bne       (bne),
      .bgez      (bgez),
      .bltz      (bltz),
      .bgtz      (bgtz),
      .blez      (blez),
      .jump0     (jump0),
      .jump1     (jump1),
      .jr_sel    (jr_sel),
      .rt0       (rt0),
      .zero      (zero),
      .neg       (neg),
      .next_pc   (next_pc),
      .misaligned(misaligned)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state    <= FETCH;
         pc       <= RESET_PC;
         instr    <= '0;
         addr_err <= 1'b0;
      end else begin
         addr_err <= consume & misaligned;
         if (state == FETCH && imem_rdy) begin
            instr <= imem_rdata;
            state <= HOLD;
         end else if (consume) begin
            pc    <= next_pc;
            state <= FETCH;
         end
      end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: vector table plus hand sequences, fetch addresses checked via expected queue
module tb_instr_fetch;
   logic        clk, rst_n, imem_req, imem_rdy, instr_valid, dec_ready, addr_err;
   logic [31:0] imem_addr, imem_rdata, instr, pc, pc_plus4, rs_val;
   logic        beq, bne, bgez, bltz, bgtz, blez, jump0, jump1, jr_sel, rt0, zero, neg;
   int          tests = 0;
   int          fails = 0;
   logic [31:0] exp_q[$];

   typedef struct {
      logic [31:0] pc, ins;
      logic [7:0]  br;
      logic        jr, r0, z, n;
      logic [31:0] rs, nxt;
      logic        err;
   } vec_t;
   vec_t vecs[16];

   instr_fetch dut (
      .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rdy(imem_rdy), .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
      .dec_ready(dec_ready), .pc(pc), .pc_plus4(pc_plus4), .beq(beq), .bne(bne),
      .bgez(bgez), .bltz(bltz), .bgtz(bgtz), .blez(blez), .jump0(jump0), .jump1(jump1),
      .jr_sel(jr_sel), .rt0(rt0), .zero(zero), .neg(neg), .rs_val(rs_val), .addr_err(addr_err)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive_ctrl(input logic [7:0] br, input logic jr, r0, z, n, input logic [31:0] rs);
      {beq, bne, bgez, bltz, bgtz, blez, jump0, jump1} = br;
      jr_sel = jr;
      rt0 = r0;
      zero = z;
      neg = n;
      rs_val = rs;
   endtask

   // called at a negedge in HOLD; consumes once and checks the addr_err pulse and its clearing
   task automatic consume(input logic [7:0] br, input logic jr, r0, z, n,
                          input logic [31:0] rs, nxt, input logic err);
      drive_ctrl(br, jr, r0, z, n, rs);
      dec_ready = 1;
      exp_q.push_back(nxt);
      @(negedge clk);
      dec_ready = 0;
      drive_ctrl(8'h00, 0, 0, 0, 0, 32'h0);
      chk("addr_err_pulse", {31'b0, addr_err}, {31'b0, err});
      chk("consume_to_fetch", {31'b0, instr_valid}, 32'd0);
      @(negedge clk);
      chk("addr_err_clear", {31'b0, addr_err}, 32'd0);
   endtask

   // called at a negedge in FETCH; checks the address, waits, returns at a negedge in HOLD
   task automatic fetch(input logic [31:0] data, input int wait_cyc);
      int n = 0;
      while (!imem_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("fetch_req", {31'b0, imem_req}, 32'd1);
      if (exp_q.size() == 0) begin
         fails++;
         tests++;
         $display("FAIL fetch_addr: got %h expected none queued", imem_addr);
      end else chk("fetch_addr", imem_addr, exp_q.pop_front());
      imem_rdata = data;
      repeat (wait_cyc) begin
         @(negedge clk);
         chk("wait_req", {31'b0, imem_req}, 32'd1);
         chk("wait_valid", {31'b0, instr_valid}, 32'd0);
      end
      imem_rdy = 1;
      @(negedge clk);
      imem_rdy = 0;
      chk("fetch_valid", {31'b0, instr_valid}, 32'd1);
      chk("fetch_instr", instr, data);
   endtask

   initial begin
      vecs[0]  = '{32'h0000_0040, 32'h1000_FFFE, 8'b1000_0000, 0, 0, 1, 0, 32'h0, 32'h0000_003C, 0};
      vecs[1]  = '{32'h0000_0040, 32'h1000_FFFE, 8'b1000_0000, 0, 0, 0, 0, 32'h0, 32'h0000_0044, 0};
      vecs[2]  = '{32'h1000_0010, 32'h0800_0100, 8'b0000_0010, 0, 0, 0, 0, 32'h0, 32'h1000_0400, 0};
      vecs[3]  = '{32'h1000_0010, 32'h0000_0008, 8'b0000_0001, 1, 0, 0, 0, 32'h203, 32'h0000_0200, 1};
      vecs[4]  = '{32'h0000_0100, 32'h0400_0004, 8'b0011_0000, 0, 0, 0, 1, 32'h0, 32'h0000_0114, 0};
      vecs[5]  = '{32'h0000_0100, 32'h0400_0004, 8'b0011_0000, 0, 1, 0, 1, 32'h0, 32'h0000_0104, 0};
      vecs[6]  = '{32'h0000_0200, 32'h1800_0008, 8'b0000_0100, 0, 0, 1, 0, 32'h0, 32'h0000_0224, 0};
      vecs[7]  = '{32'h0000_0300, 32'h1400_FFFF, 8'b0100_0000, 0, 0, 0, 0, 32'h0, 32'h0000_0300, 0};
      vecs[8]  = '{32'h0000_0300, 32'h1C00_0001, 8'b0000_1000, 0, 0, 0, 0, 32'h0, 32'h0000_0308, 0};
      vecs[9]  = '{32'h0000_0300, 32'h1C00_0001, 8'b0000_1000, 0, 0, 0, 1, 32'h0, 32'h0000_0304, 0};
      vecs[10] = '{32'hFFFF_FFFC, 32'h0000_0000, 8'b0000_0000, 0, 0, 0, 0, 32'h0, 32'h0000_0000, 0};
      vecs[11] = '{32'h2000_0000, 32'h0FFF_FFFF, 8'b0000_0001, 0, 0, 0, 0, 32'h0, 32'h2FFF_FFFC, 0};
      vecs[12] = '{32'h0000_0500, 32'h0000_0010, 8'b1000_0001, 1, 0, 1, 0, 32'h600, 32'h0000_0600, 0};
      vecs[13] = '{32'h0000_0500, 32'h0000_0010, 8'b1000_0010, 0, 0, 1, 0, 32'h0, 32'h0000_0040, 0};
      vecs[14] = '{32'h0000_0040, 32'h0401_FFF0, 8'b0011_0000, 0, 1, 0, 0, 32'h0, 32'h0000_0004, 0};
      vecs[15] = '{32'h0000_0040, 32'h0400_0010, 8'b0011_0000, 0, 0, 0, 0, 32'h0, 32'h0000_0044, 0};
      rst_n = 0;
      imem_rdy = 0;
      imem_rdata = 0;
      dec_ready = 0;
      drive_ctrl(8'h00, 0, 0, 0, 0, 32'h0);
      #1;
      chk("rst_valid", {31'b0, instr_valid}, 32'd0);
      chk("rst_pc", pc, 32'h0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_addr_err", {31'b0, addr_err}, 32'd0);
      repeat (2) @(negedge clk);
      // zero-wait memory, decode always ready: one instruction every two cycles
      imem_rdy = 1;
      dec_ready = 1;
      imem_rdata = 32'h2008_0005;
      rst_n = 1;
      #1;
      chk("c1_req", {31'b0, imem_req}, 32'd1);
      chk("c1_addr", imem_addr, 32'h0);
      chk("c1_valid", {31'b0, instr_valid}, 32'd0);
      @(negedge clk);
      chk("c2_valid", {31'b0, instr_valid}, 32'd1);
      chk("c2_instr", instr, 32'h2008_0005);
      chk("c2_pc", pc, 32'h0);
      chk("c2_pc4", pc_plus4, 32'h4);
      chk("c2_req", {31'b0, imem_req}, 32'd0);
      @(negedge clk);
      imem_rdy = 0;
      dec_ready = 0;
      chk("c3_req", {31'b0, imem_req}, 32'd1);
      exp_q.push_back(32'h4);
      fetch(32'h0, 0);
      foreach (vecs[i]) begin
         consume(8'b0000_0001, 1, 0, 0, 0, vecs[i].pc, vecs[i].pc, 0);
         fetch(vecs[i].ins, i % 3);
         chk("vec_pc", pc, vecs[i].pc);
         chk("vec_pc4", pc_plus4, vecs[i].pc + 32'd4);
         consume(vecs[i].br, vecs[i].jr, vecs[i].r0, vecs[i].z, vecs[i].n, vecs[i].rs, vecs[i].nxt, vecs[i].err);
         fetch(32'h0000_0000, 0);
      end
      // slow memory, then decode stalls while a stray imem_rdy arrives in HOLD
      consume(8'b0000_0001, 1, 0, 0, 0, 32'h700, 32'h700, 0);
      fetch(32'hABCD_1234, 5);
      imem_rdy = 1;
      imem_rdata = 32'hDEAD_BEEF;
      repeat (3) begin
         @(negedge clk);
         chk("stall_valid", {31'b0, instr_valid}, 32'd1);
         chk("stall_req", {31'b0, imem_req}, 32'd0);
         chk("stall_instr", instr, 32'hABCD_1234);
         chk("stall_pc", pc, 32'h700);
      end
      imem_rdy = 0;
      consume(8'h00, 0, 0, 0, 0, 32'h0, 32'h704, 0);
      fetch(32'h0, 0);
      // reset while holding an instruction at 0x80
      consume(8'b0000_0001, 1, 0, 0, 0, 32'h80, 32'h80, 0);
      fetch(32'h1111_1111, 0);
      chk("hold_pc80", pc, 32'h80);
      rst_n = 0;
      #1;
      chk("mid_rst_valid", {31'b0, instr_valid}, 32'd0);
      chk("mid_rst_pc", pc, 32'h0);
      chk("mid_rst_instr", instr, 32'h0);
      @(negedge clk);
      rst_n = 1;
      exp_q.delete();
      exp_q.push_back(32'h0);
      fetch(32'h2222_2222, 0);
      chk("post_rst_pc", pc, 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have ports clk input 1 clock; rst_n input 1 asynchronous active-low reset; all logic on posedge clk.
REQ-003 SHALL have ports imem_req output 1 fetch request; imem_addr output 32 word-aligned fetch address; imem_rdy input 1 read data valid; imem_rdata input 32 instruction word.
REQ-004 SHALL have ports instr output 32 held instruction; instr_valid output 1 instr is live; dec_ready input 1 decode/execute consumes instr this cycle.
REQ-005 SHALL have ports pc output 32 address of instr; pc_plus4 output 32 pc+4 (jal link value).
REQ-006 SHALL have redirect ports beq, bne, bgez, bltz, bgtz, blez, jump0, jump1 input 1 each, driven by the control decoder from instr; jr_sel input 1 (R-format funct==jr); rt0 input 1 (instr rt[0]); zero input 1 and neg input 1 (ALU compare flags); rs_val input 32; all sampled only on consume.
REQ-007 SHALL have port addr_err output 1 one-cycle pulse on misaligned jr target.

Function
REQ-008 SHALL implement FSM {FETCH, HOLD}; FETCH: imem_req=1, imem_addr=pc; on imem_rdy capture imem_rdata into instr, go HOLD.
REQ-009 In HOLD SHALL drive instr_valid=1, imem_req=0; instr and pc stable until consume.
REQ-010 Consume SHALL be instr_valid & dec_ready; on consume pc<=next_pc, go FETCH; no consume keeps HOLD indefinitely.
REQ-011 Fetch-to-valid latency SHALL be one cycle after the imem_rdy cycle; imem_rdy in FETCH same cycle as entry is legal (zero-wait memory: one instruction per 2 cycles).
REQ-012 imem_rdy outside FETCH SHALL be ignored.
REQ-013 next_pc priority SHALL be: jump1&jr_sel -> {rs_val[31:2],2'b00}; else jump0|jump1 -> {pc_plus4[31:28],instr[25:0],2'b00}; else taken -> pc_plus4+(sext(instr[15:0])<<2); else pc_plus4.
REQ-014 taken SHALL be beq&zero | bne&~zero | bgtz&~neg&~zero | blez&(neg|zero) | bgez&rt0&~neg | bltz&~rt0&neg (bgez/bltz share opcode; rt0 splits them).
REQ-015 All address arithmetic SHALL be 32-bit modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0 without flag.
REQ-016 addr_err SHALL pulse one cycle on consume with jump1&jr_sel&(rs_val[1:0]!=0); fetch proceeds at the truncated address.
REQ-017 pc_plus4 SHALL be combinational pc+4.
REQ-018 Branch offset SHALL sign-extend bit 15; negative offsets move backward.

Reset
REQ-019 On rst_n low SHALL asynchronously set state=FETCH, pc=RESET_PC, instr=0, instr_valid=0, addr_err=0; imem_req=1 from first cycle after release.
REQ-020 Reset mid-FETCH or mid-HOLD SHALL abandon the access; late imem_rdy after release is treated as a response to RESET_PC.

Structure
REQ-021 Shared package SHALL hold state encoding (FETCH=1'b0, HOLD=1'b1), RESET_PC default, instruction field bit positions.
REQ-022 next_pc/taken logic SHALL be a combinational sub-module next_pc_sel; instr_fetch holds FSM and registers.

Verification
REQ-023 Reset release, imem_rdy=1 always, rdata=32'h2008_0005, dec_ready=1 -> imem_addr 0, instr_valid in cycle 2, next fetch addr 4.
REQ-024 pc=0x40, beq=1, zero=1, instr[15:0]=16'hFFFE -> next imem_addr 0x3C; same with zero=0 -> 0x44.
REQ-025 pc=0x1000_0010, jump0=1, instr[25:0]=26'h000_0100 -> next addr 0x1000_0400; jump1=1, jr_sel=1, rs_val=0x0000_0203 -> addr 0x200, addr_err one-cycle pulse.
REQ-026 bgez=bltz=1, neg=1: rt0=0 -> taken; rt0=1 -> pc+4; blez with zero=1 -> taken.
REQ-027 imem_rdy held low 5 cycles then high; dec_ready low 3 cycles in HOLD -> instr/pc stable, imem_req low in HOLD, single consume.
REQ-028 rst_n asserted in HOLD at pc=0x80 -> instr_valid drops immediately, next fetch 0x0.
